if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of id_stage and drives its instr input.
//   Holds the PC, fetches over a one-outstanding req/rdy imem port, honours ID stall and EX redirect (branch/jump).
//   Wrong-path responses are discarded; ID stalls that race a returning fetch are absorbed in a one-entry skid buffer.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset
//   NOP_INSTR  32'h0000_0013  instruction presented to ID when if_id_valid=0 (addi x0,x0,0)
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   reset        in   1   synchronous, active-high
//   stall        in   1   ID hazard stall: hold IF/ID register
//   redirect     in   1   EX taken branch/jump: flush and refetch
//   redirect_pc  in   32  redirect target; bits [1:0] forced to 0 on load
//   imem_req     out  1   fetch request valid
//   imem_addr    out  32  fetch address; stable while imem_req=1 until imem_rdy=1
//   imem_rdy     in   1   response valid this cycle (only meaningful while imem_req=1)
//   imem_rdata   in   32  instruction word, valid when imem_rdy=1
//   if_id_valid  out  1   IF/ID holds a real instruction
//   if_id_pc     out  32  PC of if_id_instr
//   if_id_instr  out  32  instruction to ID (NOP_INSTR when invalid)
// BEHAVIOUR
//   Reset (sync, active-high): pc=RESET_PC, state=FETCH, skid empty, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR;
//     imem_req=0 during reset cycle; first request (addr RESET_PC) in first cycle after reset deasserts.
//     Reset mid-fetch abandons the outstanding request; imem_rdy during reset is ignored.
//   States: FETCH (req=1, addr=pc), HOLD (req=0, skid full), DISCARD (req=1, addr=stale_addr, response dropped).
//   Priority each cycle: reset > redirect > stall > normal.
//   FETCH:
//     redirect & imem_rdy  : drop rdata; pc<=redirect_pc; stay FETCH (new addr next cycle).
//     redirect & !imem_rdy : stale_addr<=pc; pc<=redirect_pc; ->DISCARD.
//     imem_rdy & !stall    : IF/ID<={1,pc,rdata}; pc<=pc+4; stay FETCH (back-to-back, next addr next cycle).
//     imem_rdy & stall     : skid<={pc,rdata}; pc<=pc+4; ->HOLD.
//     !imem_rdy            : stay; addr unchanged.
//   HOLD: redirect -> skid cleared, pc<=redirect_pc, ->FETCH; !stall -> IF/ID<={1,skid}, ->FETCH; stall -> stay.
//   DISCARD: imem_rdy -> drop rdata, ->FETCH (addr=pc next cycle); further redirect -> pc<=newest redirect_pc, stay.
//   IF/ID register:
//     redirect         : valid<=0, instr<=NOP_INSTR (flush overrides stall); pc<=0.
//     stall & !redirect: hold all three outputs.
//     !stall, no instr : bubble: valid<=0, instr<=NOP_INSTR, pc<=0.
//   Latency: imem_rdy at cycle N -> on if_id_* at N+1 (no stall). Zero-wait memory sustains 1 instr/cycle.
//   pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No misalignment check beyond forcing [1:0]=0.
//   At most one request outstanding; imem_addr never changes while req=1 and rdy=0.
// TESTING
//   Reset, zero-wait imem returning pc-indexed words -> if_id_pc 0,4,8,... one per cycle from cycle 2; valid=1.
//   imem_rdy delayed 3 cycles for addr 0x8 -> imem_addr held 0x8 for 4 cycles; ID sees 3 bubbles (NOP, valid=0).
//   stall high same cycle as rdy for 0xC (rdata 0xDEAD_BEEF) for 2 cycles -> IF/ID holds 0x8 entry, req=0;
//     stall drops -> if_id_pc=0xC, instr=0xDEAD_BEEF next cycle; fetch resumes at 0x10.
//   redirect to 0x103 while fetch of 0x20 outstanding -> DISCARD; 0x20 data never reaches ID; next req addr=0x100.
//   redirect while HOLD with stall=1 -> if_id_valid=0 next cycle, skid dropped, req addr=redirect target.
//   pc=32'hFFFF_FFFC fetched -> next req addr 0x0; reset asserted mid-wait -> outputs return to reset values.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: one-outstanding imem fetch,
// ID stall absorbed in a one-entry skid buffer, EX redirect flushes and discards wrong-path data.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] stale_q, stale_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        valid_q, valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;

    logic        new_vld;
    logic [31:0] new_pc, new_instr;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        new_vld      = 1'b0;
        new_pc       = pc_q;
        new_instr    = imem_rdata;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d = target;
                    // Request still in flight: its response must be swallowed later.
                    if (!imem_rdy) begin
                        stale_d = pc_q;
                        state_d = S_DISCARD;
                    end
                end else if (imem_rdy) begin
                    pc_d = pc_q + 32'd4;
                    if (stall) begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end else begin
                        new_vld = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    new_vld   = 1'b1;
                    new_pc    = skid_pc_q;
                    new_instr = skid_instr_q;
                    state_d   = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (redirect) pc_d = target;
                if (imem_rdy) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Flush beats stall; a stall holds the register; otherwise load or bubble.
        valid_d    = valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (redirect || !stall) begin
            valid_d    = new_vld && !redirect;
            id_pc_d    = valid_d ? new_pc : 32'd0;
            id_instr_d = valid_d ? new_instr : NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            stale_q      <= 32'd0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= NOP_INSTR;
            valid_q      <= 1'b0;
            id_pc_q      <= 32'd0;
            id_instr_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_q      <= stale_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            valid_q      <= valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
        end
    end

    assign imem_req    = !reset && (state_q != S_HOLD);
    assign imem_addr   = (state_q == S_DISCARD) ? stale_q : pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_instr = id_instr_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scripted cycle table for the corner cases, then random traffic
// checked against an in-order instruction-stream model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, imem_rdy;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_pc, if_id_instr;

    int checks = 0;
    int failures = 0;

    if_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stl, rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc, instr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mk(input logic rst, input logic stl, input logic rdr,
                                input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] pc, input logic [31:0] instr);
        vec_t r;
        r.rst = rst; r.stl = stl; r.rdr = rdr; r.rpc = rpc; r.rdy = rdy; r.rdata = rdata;
        r.req = req; r.addr = addr; r.v = v; r.pc = pc; r.instr = instr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int consumed = 0;

    initial begin
        logic [31:0] exp_pc, prev_addr;
        logic        prev_pend;

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_rdy = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);

        //            rst stl rdr rpc            rdy rdata            req addr           v  pc             instr
        tbl.push_back(mk(1, 0, 0, 0,            1, 32'h1,           0, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h0),       1, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h4),       1, 32'h4,        1, 32'h0,        mw(32'h0)));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h0,           1, 32'h8,        1, 32'h4,        mw(32'h4)));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h0,           1, 32'h8,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h0,           1, 32'h8,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h8),       1, 32'h8,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'hDEAD_BEEF,   1, 32'hC,        1, 32'h8,        mw(32'h8)));
        tbl.push_back(mk(0, 1, 0, 0,            0, 32'h0,           0, 32'h10,       1, 32'h8,        mw(32'h8)));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h0,           0, 32'h10,       1, 32'h8,        mw(32'h8)));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h10),      1, 32'h10,       1, 32'hC,        32'hDEAD_BEEF));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h14),      1, 32'h14,       1, 32'h10,       mw(32'h10)));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h18),      1, 32'h18,       1, 32'h14,       mw(32'h14)));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h1C),      1, 32'h1C,       1, 32'h18,       mw(32'h18)));
        tbl.push_back(mk(0, 0, 1, 32'h103,      0, 32'h0,           1, 32'h20,       1, 32'h1C,       mw(32'h1C)));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h0,           1, 32'h20,       0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h20),      1, 32'h20,       0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h100),     1, 32'h100,      0, 32'h0,        NOP));
        tbl.push_back(mk(0, 1, 0, 0,            1, mw(32'h104),     1, 32'h104,      1, 32'h100,      mw(32'h100)));
        tbl.push_back(mk(0, 1, 1, 32'h200,      0, 32'h0,           0, 32'h108,      1, 32'h100,      mw(32'h100)));
        tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFE,0, 32'h0,           1, 32'h200,      0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'h200),     1, 32'h200,      0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            1, mw(32'hFFFF_FFFC),1, 32'hFFFF_FFFC,0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h0,           1, 32'h0,        1, 32'hFFFF_FFFC, mw(32'hFFFF_FFFC)));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h0,           1, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(1, 0, 0, 0,            1, 32'h0,           0, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h0,           1, 32'h0,        0, 32'h0,        NOP));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; stall = tbl[i].stl; redirect = tbl[i].rdr;
            redirect_pc = tbl[i].rpc; imem_rdy = tbl[i].rdy; imem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("t%0d_req", i),   {31'd0, imem_req},    {31'd0, tbl[i].req});
            chk($sformatf("t%0d_addr", i),  imem_addr,            tbl[i].addr);
            chk($sformatf("t%0d_valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].v});
            chk($sformatf("t%0d_pc", i),    if_id_pc,             tbl[i].pc);
            chk($sformatf("t%0d_instr", i), if_id_instr,          tbl[i].instr);
        end

        // Random traffic: ID must see exactly the in-order stream from the last reset/redirect.
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_rdy = 1'b0;
        @(negedge clk);
        exp_pc = 32'h0; prev_pend = 1'b0; prev_addr = '0;
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            imem_rdy    = ($urandom_range(0, 9) < 6);
            imem_rdata  = imem_rdy ? mw(imem_addr) : $urandom;
            #1;
            if (!if_id_valid) begin
                chk("rnd_bubble_pc", if_id_pc, 32'h0);
                chk("rnd_bubble_instr", if_id_instr, NOP);
            end
            if (reset) chk("rnd_req_in_reset", {31'd0, imem_req}, 32'd0);
            else if (prev_pend) begin
                chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_held", imem_addr, prev_addr);
            end
            if (reset) exp_pc = 32'h0;
            else if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
            else if (if_id_valid && !stall) begin
                chk("rnd_stream_pc", if_id_pc, exp_pc);
                chk("rnd_stream_instr", if_id_instr, mw(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            prev_pend = imem_req && !imem_rdy && !redirect && !reset;
            prev_addr = imem_addr;
            @(negedge clk);
        end
        checks++;
        if (consumed < 300) begin
            failures++;
            $display("FAIL rnd_progress: got %0d instructions expected at least 300", consumed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
